// File: rtl/flow_led.sv
// flow_led: one-hot running light on an LED bank, optional ping-pong bounce via FLOW_LED_PINGPONG_EN
module flow_led #(
  parameter int LED_W       = 8,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  output logic [LED_W-1:0] led_out
);
  localparam int               CW   = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]    LAST = CW'(STEP_CYCLES - 1);
  localparam logic [LED_W-1:0] HOME = LED_W'(1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             tick, one_hot;
  assign tick    = cnt_q == LAST;
  assign one_hot = (led_q != '0) && ((led_q & (led_q - LED_W'(1))) == '0);
  assign led_out = led_q;
  // prescaler counts 0..STEP_CYCLES-1 and wraps on the tick
  always_comb cnt_d = tick ? '0 : cnt_q + CW'(1);
`ifdef FLOW_LED_PINGPONG_EN
  logic dir_q, dir_d;
  // bounce between the end bits; direction flips on the tick that lands on an end
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    if (tick && !one_hot) begin
      led_d = HOME;
      dir_d = 1'b0;
    end else if (tick && !dir_q) begin
      led_d = led_q << 1;
      dir_d = led_d[LED_W-1];
    end else if (tick) begin
      led_d = led_q >> 1;
      dir_d = !led_d[0];
    end
  end
  // direction register, 0 = left
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) dir_q <= 1'b0;
    else         dir_q <= dir_d;
`else
  // rotate left on each tick; a corrupted pattern recovers to the home LED
  always_comb led_d = !tick ? led_q : one_hot ? {led_q[LED_W-2:0], led_q[LED_W-1]} : HOME;
`endif
  // prescaler and LED state registers
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      cnt_q <= '0;
      led_q <= HOME;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
endmodule

// File: tb/tb_flow_led.sv
// tb_flow_led: scoreboard bench for flow_led (step of 4 and step of 1 instances)
module tb_flow_led;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] led4, led1;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } item_t;
  item_t q[$];

`ifdef FLOW_LED_PINGPONG_EN
  localparam int LEN = 14;
  logic [7:0] tbl [0:13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                             8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
`else
  localparam int LEN = 8;
  logic [7:0] tbl [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`endif

  flow_led #(.LED_W(8), .STEP_CYCLES(4)) dut  (.sys_clk(sys_clk), .sys_rst(sys_rst), .led_out(led4));
  flow_led #(.LED_W(8), .STEP_CYCLES(1)) dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .led_out(led1));

  always #10 sys_clk = ~sys_clk;

  function automatic logic [7:0] pat(int n);
    return tbl[n % LEN];
  endfunction

  task automatic push(input int sel, input logic [7:0] exp, input string name);
    item_t it;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
  endtask

  initial begin
    item_t      it;
    logic [7:0] got;
    forever begin
      @(negedge sys_clk);
      #1;
      while (q.size() > 0) begin
        it  = q.pop_front();
        got = it.sel == 1 ? led1 : led4;
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", it.name, got, it.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found = 1'b0;
    @(negedge sys_clk);
    push(0, 8'h01, "reset4");
    push(1, 8'h01, "reset1");
    sys_rst = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge sys_clk);
      push(0, pat(k / 4), "step4");
      push(1, pat(k), "step1");
      if (k >= 60 && k % 4 == 0 && pat(k / 4) == 8'h10) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL find_10: got none expected %h", 8'h10);
    end
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    @(negedge sys_clk);
    push(0, 8'h01, "async_rst4");
    push(1, 8'h01, "async_rst1");
    sys_rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge sys_clk);
      push(0, k <= 8 ? pat(k / 4) : k <= 11 ? 8'h03 : k <= 15 ? 8'h01 : 8'h02,
           k <= 8 ? "restart4" : "recover4");
      push(1, pat(k), "restart1");
      if (k == 8) begin
        #3 force dut.led_q = 8'h03;
        #1 release dut.led_q;
      end
    end
    @(negedge sys_clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
